i2s_apb_bist: RTL and testbench

- Synthesizable APB-master self-test engine that replaces the simulation-only loopback scoreboard.
- Configures a transmitting I2S_top and a receiving I2S_top over the shared APB bus.
- Streams LFSR-generated words into the Tx FIFO, reads the Rx FIFO, regenerates the expected sequence and counts mismatches.
- Sits beside the transceiver pair in the loopback/BIST harness; generalised in word count, address map, burst size and word width.

---
 rtl/i2s_bist_pkg.sv | 34 +++
 rtl/i2s_bist_lfsr.sv | 22 ++
 rtl/i2s_apb_bist.sv | 198 +++++++++++++++++++
 tb/tb_i2s_apb_bist.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_bist_pkg.sv
// Shared types and helpers for the I2S APB loopback self-test engine.
package i2s_bist_pkg;

  typedef enum logic [1:0] {
    WS_16     = 2'd0,
    WS_24     = 2'd1,
    WS_32     = 2'd2,
    WS_32_ALT = 2'd3
  } word_size_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CFG_TX, ST_CFG_RX, ST_PRELOAD, ST_GO, ST_RUN, ST_HALT, ST_DONE
  } state_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  function automatic int unsigned word_width(input logic [1:0] ws);
    case (word_size_e'(ws))
      WS_16:   return 16;
      WS_24:   return 24;
      default: return 32;
    endcase
  endfunction

  // Sample word is the top W bits of the LFSR state, right-aligned.
  function automatic logic [31:0] word_of(input logic [31:0] q, input logic [1:0] ws);
    return q >> (32 - word_width(ws));
  endfunction

  function automatic logic [31:0] word_mask(input logic [1:0] ws);
    return 32'hFFFF_FFFF >> (32 - word_width(ws));
  endfunction

endpackage

// File: rtl/i2s_bist_lfsr.sv
// 32-bit Galois LFSR; a zero seed is replaced by 1 so the sequence never locks up.
module i2s_bist_lfsr
  import i2s_bist_pkg::*;
(
  input  logic        pclk,
  input  logic        preset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        adv,
  output logic [31:0] q
);

  logic [31:0] seed_eff;
  assign seed_eff = (seed == 32'h0) ? 32'h1 : seed;

  always_ff @(posedge pclk) begin
    if (!preset)   q <= seed_eff;
    else if (load) q <= seed_eff;
    else if (adv)  q <= (q >> 1) ^ (q[0] ? LFSR_POLY : 32'h0);
  end

endmodule

// File: rtl/i2s_apb_bist.sv
// APB-master BIST: configures Tx/Rx I2S instances, streams LFSR words, checks readback.
// Optional watchdog enabled by defining I2S_BIST_TIMEOUT_EN.
module i2s_apb_bist
  import i2s_bist_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 256,
  parameter int unsigned PRELOAD   = 15,
  parameter logic [31:0] TX_BASE   = 32'h00,
  parameter logic [31:0] RX_BASE   = 32'h20,
  parameter logic [31:0] DATA_OFF  = 32'h04,
  parameter logic [31:0] RDATA_OFF = 32'h08,
  parameter int unsigned STOP_BIT  = 1,
  parameter logic [31:0] SEED      = 32'h1,
  parameter int unsigned TO_CYCLES = 65536
)(
  input  logic        pclk,
  input  logic        preset,
  input  logic        start,
  input  logic [31:0] cfg_tx,
  input  logic [31:0] cfg_rx,
  input  logic [1:0]  word_size,
  input  logic        tx_full,
  input  logic        rx_empty,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_cnt,
  output logic [15:0] first_err,
  output logic [15:0] rx_cnt,
  output logic        timeout
);

  localparam logic [15:0] NUM_W        = 16'(NUM_WORDS);
  localparam logic [15:0] PRE_W        = 16'(PRELOAD);
  localparam logic [31:0] STOP_MASK    = 32'h1 << STOP_BIT;
  localparam logic [31:0] TX_DATA_ADDR = TX_BASE + DATA_OFF;
  localparam logic [31:0] RX_DATA_ADDR = RX_BASE + RDATA_OFF;

  state_e      state_q, state_d;
  logic [31:0] cfg_tx_q, cfg_tx_d, cfg_rx_q, cfg_rx_d;
  logic [1:0]  ws_q, ws_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic        psel_d, penable_d, pwrite_d, busy_d, done_d, pass_d;
  logic [31:0] paddr_d, pwdata_d;
  logic [15:0] err_cnt_d, first_err_d, rx_cnt_d;
  logic        req, req_wr, mismatch, lfsr_load, gen_adv, exp_adv;
  logic [31:0] req_addr, req_data, gen_q, exp_q;
  logic        free, xfer_done;

`ifdef I2S_BIST_TIMEOUT_EN
  localparam logic [31:0] TO_LIM = 32'(TO_CYCLES);
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        timeout_d;
`else
  logic unused_to;
  assign unused_to = ^32'(TO_CYCLES);
  assign timeout   = 1'b0;
`endif

  assign free      = !psel;
  assign xfer_done = psel && penable;

  i2s_bist_lfsr u_gen (.pclk(pclk), .preset(preset), .load(lfsr_load), .seed(SEED), .adv(gen_adv), .q(gen_q));
  i2s_bist_lfsr u_exp (.pclk(pclk), .preset(preset), .load(lfsr_load), .seed(SEED), .adv(exp_adv), .q(exp_q));

  always_comb begin
    state_d = state_q;  cfg_tx_d = cfg_tx_q;  cfg_rx_d = cfg_rx_q;  ws_d = ws_q;
    tx_cnt_d = tx_cnt_q;  rx_cnt_d = rx_cnt;  err_cnt_d = err_cnt;  first_err_d = first_err;
    busy_d = busy;  done_d = done;  pass_d = pass;
    psel_d = psel;  penable_d = penable;  pwrite_d = pwrite;  paddr_d = paddr;  pwdata_d = pwdata;
    req = 1'b0;  req_wr = 1'b1;  req_addr = 32'h0;  req_data = 32'h0;
    mismatch = 1'b0;  lfsr_load = 1'b0;  gen_adv = 1'b0;  exp_adv = 1'b0;
`ifdef I2S_BIST_TIMEOUT_EN
    to_cnt_d = to_cnt_q;  timeout_d = timeout;
    if (state_q == ST_RUN) begin
      if (xfer_done && !pwrite) to_cnt_d = 32'h0;
      else if (to_cnt_q < TO_LIM) to_cnt_d = to_cnt_q + 32'd1;
    end
`endif
    // Setup -> access -> idle; every transfer is followed by one free decision cycle
    if (psel && !penable) penable_d = 1'b1;
    if (xfer_done) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_CFG_TX;  busy_d = 1'b1;  done_d = 1'b0;  pass_d = 1'b0;
        err_cnt_d = 16'h0;  rx_cnt_d = 16'h0;  tx_cnt_d = 16'h0;  first_err_d = 16'hFFFF;
        cfg_tx_d = cfg_tx;  cfg_rx_d = cfg_rx;  ws_d = word_size;  lfsr_load = 1'b1;
`ifdef I2S_BIST_TIMEOUT_EN
        to_cnt_d = 32'h0;  timeout_d = 1'b0;
`endif
      end
      ST_CFG_TX: begin
        req = 1'b1;  req_addr = TX_BASE;  req_data = cfg_tx_q;
        if (xfer_done) state_d = ST_CFG_RX;
      end
      ST_CFG_RX: begin
        req = 1'b1;  req_addr = RX_BASE;  req_data = cfg_rx_q | STOP_MASK;
        if (xfer_done) state_d = (PRE_W == 16'h0) ? ST_GO : ST_PRELOAD;
      end
      ST_PRELOAD: begin
        req = !tx_full;  req_addr = TX_DATA_ADDR;  req_data = word_of(gen_q, ws_q);
        if (xfer_done) begin
          gen_adv  = 1'b1;
          tx_cnt_d = tx_cnt_q + 16'd1;
          if (tx_cnt_q + 16'd1 == PRE_W) state_d = ST_GO;
        end
      end
      ST_GO: begin
        req = 1'b1;  req_addr = RX_BASE;  req_data = cfg_rx_q & ~STOP_MASK;
        if (xfer_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (xfer_done && !pwrite) begin
          exp_adv  = 1'b1;
          rx_cnt_d = rx_cnt + 16'd1;
          mismatch = (prdata & word_mask(ws_q)) != word_of(exp_q, ws_q);
        end
        if (xfer_done && pwrite) begin
          gen_adv  = 1'b1;
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
        // Read has priority so the Rx FIFO never overflows while Tx keeps up
        if (free) begin
          if (rx_cnt == NUM_W) state_d = ST_HALT;
`ifdef I2S_BIST_TIMEOUT_EN
          else if (to_cnt_q >= TO_LIM) begin
            state_d   = ST_HALT;
            timeout_d = 1'b1;
          end
`endif
          else if (!rx_empty && rx_cnt < NUM_W) begin
            req = 1'b1;  req_wr = 1'b0;  req_addr = RX_DATA_ADDR;
          end else if (!tx_full && tx_cnt_q < NUM_W) begin
            req = 1'b1;  req_addr = TX_DATA_ADDR;  req_data = word_of(gen_q, ws_q);
          end
        end
      end
      ST_HALT: begin
        req = 1'b1;  req_addr = RX_BASE;  req_data = cfg_rx_q | STOP_MASK;
        if (xfer_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;  done_d = 1'b1;  busy_d = 1'b0;
        pass_d  = (err_cnt == 16'h0) && !timeout;
      end
      default: state_d = ST_IDLE;
    endcase

    if (mismatch) begin
      if (err_cnt != 16'hFFFF) err_cnt_d = err_cnt + 16'd1;
      if (err_cnt == 16'h0)    first_err_d = rx_cnt;
    end

    if (free && req) begin
      psel_d   = 1'b1;
      pwrite_d = req_wr;
      paddr_d  = req_addr;
      pwdata_d = req_data;
    end
  end

  always_ff @(posedge pclk) begin
    if (!preset) begin
      state_q <= ST_IDLE;  cfg_tx_q <= 32'h0;  cfg_rx_q <= 32'h0;  ws_q <= 2'd0;  tx_cnt_q <= 16'h0;
      psel <= 1'b0;  penable <= 1'b0;  pwrite <= 1'b0;  paddr <= 32'h0;  pwdata <= 32'h0;
      busy <= 1'b0;  done <= 1'b0;  pass <= 1'b0;
      err_cnt <= 16'h0;  first_err <= 16'hFFFF;  rx_cnt <= 16'h0;
    end else begin
      state_q <= state_d;  cfg_tx_q <= cfg_tx_d;  cfg_rx_q <= cfg_rx_d;  ws_q <= ws_d;  tx_cnt_q <= tx_cnt_d;
      psel <= psel_d;  penable <= penable_d;  pwrite <= pwrite_d;  paddr <= paddr_d;  pwdata <= pwdata_d;
      busy <= busy_d;  done <= done_d;  pass <= pass_d;
      err_cnt <= err_cnt_d;  first_err <= first_err_d;  rx_cnt <= rx_cnt_d;
    end
  end

`ifdef I2S_BIST_TIMEOUT_EN
  always_ff @(posedge pclk) begin
    if (!preset) begin
      to_cnt_q <= 32'h0;
      timeout  <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      timeout  <= timeout_d;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_apb_bist.sv
// Bench for i2s_apb_bist: APB slave loopback model plus ordered write scoreboard.
module tb_i2s_apb_bist;

  localparam logic [31:0] POLY = 32'h8020_0003;
  localparam int NW   = 256;
  localparam int NPRE = 15;

  logic        clk = 1'b0, preset = 1'b0, start = 1'b0;
  logic [31:0] cfg_tx = 32'h0, cfg_rx = 32'h0;
  logic [1:0]  word_size = 2'd0;
  logic        tx_full, rx_empty;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        busy, done, pass, timeout;
  logic [15:0] err_cnt, first_err, rx_cnt;

  i2s_apb_bist #(.TO_CYCLES(100)) dut (
    .pclk(clk), .preset(preset), .start(start), .cfg_tx(cfg_tx), .cfg_rx(cfg_rx),
    .word_size(word_size), .tx_full(tx_full), .rx_empty(rx_empty),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err(first_err), .rx_cnt(rx_cnt), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Loopback slave: Tx data writes land in one FIFO that the Rx data register drains
  logic [31:0] fifo[$];
  int          rd_idx = 0;
  int          corrupt_idx = -1;
  logic        rx_stop = 1'b1;
  logic        tx_full_r = 1'b0, rx_empty_r = 1'b1;
  logic        force_full = 1'b0, force_empty = 1'b0;
  logic [31:0] prdata_r = 32'h0;

  assign tx_full  = force_full | tx_full_r;
  assign rx_empty = force_empty | rx_empty_r;
  assign prdata   = prdata_r;

  always @(posedge clk) begin
    if (!preset || start) begin
      fifo.delete();
      rd_idx  <= 0;
      rx_stop <= 1'b1;
    end else if (psel && penable) begin
      if (pwrite) begin
        if (paddr == 32'h20)      rx_stop <= pwdata[1];
        else if (paddr == 32'h04) fifo.push_back(pwdata);
      end else if (fifo.size() != 0) begin
        void'(fifo.pop_front());
        rd_idx <= rd_idx + 1;
      end
    end
  end

  always @(negedge clk) begin
    tx_full_r  <= fifo.size() >= 16;
    rx_empty_r <= (fifo.size() == 0) || rx_stop;
    if (fifo.size() != 0) prdata_r <= fifo[0] ^ ((rd_idx == corrupt_idx) ? 32'h8 : 32'h0);
    else                  prdata_r <= 32'h0;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_wr[$];

  int          checks = 0, errors = 0, n_tx_wr = 0;
  logic        prev_psel = 1'b0, prev_penable = 1'b0;
  logic [31:0] prev_paddr = 32'h0, prev_pwdata = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? POLY : 32'h0);
  endfunction

  // Expected write stream of a run: config, preload, GO, remaining data, HALT
  task automatic push_run(input logic [31:0] ctx, input logic [31:0] crx, input logic [1:0] ws, input int ndata);
    logic [31:0] l = 32'h1;
    int w = (ws == 2'd0) ? 16 : (ws == 2'd1) ? 24 : 32;
    exp_wr.push_back('{32'h00, ctx});
    exp_wr.push_back('{32'h20, crx | 32'h2});
    for (int i = 0; i < ndata; i++) begin
      if (i == NPRE) exp_wr.push_back('{32'h20, crx & ~32'h2});
      exp_wr.push_back('{32'h04, l >> (32 - w)});
      l = lfsr_step(l);
    end
    exp_wr.push_back('{32'h20, crx | 32'h2});
  endtask

  // One cycle: sample at the falling edge and check any access phase on the bus
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (penable) begin
      chk("psel_with_penable", 32'(psel), 32'd1);
      chk("penable_after_setup", 32'(prev_psel && !prev_penable), 32'd1);
      chk("paddr_stable", paddr, prev_paddr);
      chk("pwdata_stable", pwdata, prev_pwdata);
      if (pwrite) begin
        chk("write_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          chk("wr_addr", paddr, e.addr);
          chk("wr_data", pwdata, e.data);
        end
        if (paddr == 32'h04) n_tx_wr++;
      end else begin
        chk("rd_addr", paddr, 32'h28);
      end
    end
    prev_psel = psel;  prev_penable = penable;  prev_paddr = paddr;  prev_pwdata = pwdata;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("done_cleared", 32'(done), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) tick();
    chk("done_within_budget", 32'(done), 32'd1);
  endtask

  task automatic end_checks(input logic [15:0] e_err, input logic [15:0] e_first,
                            input logic e_pass, input logic [15:0] e_rx, input logic e_to);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_pass", 32'(pass), 32'(e_pass));
    chk("end_err_cnt", 32'(err_cnt), 32'(e_err));
    chk("end_first_err", 32'(first_err), 32'(e_first));
    chk("end_rx_cnt", 32'(rx_cnt), 32'(e_rx));
    chk("end_timeout", 32'(timeout), 32'(e_to));
    chk("all_writes_seen", 32'(exp_wr.size()), 32'd0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_psel"}, 32'(psel), 32'd0);
    chk({tag, "_penable"}, 32'(penable), 32'd0);
    chk({tag, "_pwrite"}, 32'(pwrite), 32'd0);
    chk({tag, "_paddr"}, paddr, 32'h0);
    chk({tag, "_pwdata"}, pwdata, 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    chk({tag, "_first_err"}, 32'(first_err), 32'hFFFF);
    chk({tag, "_rx_cnt"}, 32'(rx_cnt), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    bit found;
    int n0;

    repeat (3) tick();
    reset_checks("reset");
    preset = 1'b1;
    tick();

    // Clean 32-bit loopback
    cfg_tx = 32'hA5A5_0011;  cfg_rx = 32'h1234_5679;  word_size = 2'd2;
    push_run(cfg_tx, cfg_rx, word_size, NW);
    pulse_start();
    wait_done(4000);
    end_checks(16'd0, 16'hFFFF, 1'b1, 16'(NW), 1'b0);

    // 16-bit run with bit 3 of word 7 corrupted on readback
    cfg_tx = 32'h0000_0042;  cfg_rx = 32'h0000_00C3;  word_size = 2'd0;  corrupt_idx = 7;
    push_run(cfg_tx, cfg_rx, word_size, NW);
    pulse_start();
    wait_done(4000);
    end_checks(16'd1, 16'd7, 1'b0, 16'(NW), 1'b0);
    corrupt_idx = -1;

    // Tx FIFO held full for 50 cycles at the start of preload
    cfg_tx = 32'h0000_1001;  cfg_rx = 32'h0000_0005;  word_size = 2'd1;
    push_run(cfg_tx, cfg_rx, word_size, NW);
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      found = psel && penable && pwrite && (paddr == 32'h20);
    end
    chk("cfg_rx_write_seen", 32'(found), 32'd1);
    force_full = 1'b1;
    n0 = n_tx_wr;
    repeat (50) tick();
    chk("no_writes_while_full", 32'(n_tx_wr), 32'(n0));
    chk("bus_idle_while_full", 32'(psel), 32'd0);
    force_full = 1'b0;
    tick();
    chk("resume_psel", 32'(psel), 32'd1);
    chk("resume_setup", 32'(penable), 32'd0);
    chk("resume_addr", paddr, 32'h04);
    wait_done(4000);
    end_checks(16'd0, 16'hFFFF, 1'b1, 16'(NW), 1'b0);

    // Reset pulse in the middle of RUN, then a fresh run
    word_size = 2'd3;
    push_run(cfg_tx, cfg_rx, word_size, NW);
    pulse_start();
    for (int i = 0; i < 2000 && rd_idx < 20; i++) tick();
    chk("reached_run", 32'(rd_idx >= 20), 32'd1);
    preset = 1'b0;
    tick();
    reset_checks("midrun_reset");
    preset = 1'b1;
    exp_wr.delete();
    tick();
    push_run(cfg_tx, cfg_rx, word_size, NW);
    pulse_start();
    wait_done(4000);
    end_checks(16'd0, 16'hFFFF, 1'b1, 16'(NW), 1'b0);

`ifdef I2S_BIST_TIMEOUT_EN
    // Receiver never reports data: only 16 Tx words fit, then the watchdog halts
    force_empty = 1'b1;  word_size = 2'd2;
    push_run(cfg_tx, cfg_rx, word_size, 16);
    pulse_start();
    wait_done(2000);
    end_checks(16'd0, 16'hFFFF, 1'b0, 16'd0, 1'b1);
    force_empty = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
